clock_time_controller: RTL and testbench



---
 rtl/clock_time_controller.sv | 121 ++++++++++++
 tb/tb_clock_time_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_controller.sv
// Timekeeping for an HH:MM:SS display: 1 Hz prescaler, binary time counters,
// and a two-button set sequencer (RUN -> SET_HOUR -> SET_MIN -> RUN) with blink flags.
module clock_time_controller #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic       sec_tick,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic [1:0] mode,
   output logic       blink_hour,
   output logic       blink_min
);

   localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICKS_PER_SEC / 2 - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } mode_t;

   mode_t            state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic [4:0]       hour_d;
   logic [5:0]       minute_d, second_d;
   logic             btn_mode_q, btn_inc_q;
   logic             press_mode, press_inc;
   logic             tick;

   // A simultaneous mode press swallows the inc press.
   assign press_mode = btn_mode & ~btn_mode_q;
   assign press_inc  = btn_inc & ~btn_inc_q & ~press_mode;
   assign tick       = (cnt_q == CNT_LAST);
   assign sec_tick   = tick;
   assign mode       = 2'(state_q);

   // Next-state, prescaler and time-update logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
      phase_d  = phase_q ^ ((cnt_q == CNT_HALF) | tick);
      hour_d   = hour;
      minute_d = minute;
      second_d = second;

      case (state_q)
         RUN: begin
            if (tick) begin
               if (second == 6'd59) begin
                  second_d = '0;
                  if (minute == 6'd59) begin
                     minute_d = '0;
                     hour_d   = (hour == 5'd23) ? '0 : hour + 5'd1;
                  end else begin
                     minute_d = minute + 6'd1;
                  end
               end else begin
                  second_d = second + 6'd1;
               end
            end
            if (press_mode) state_d = SET_HOUR;
         end
         SET_HOUR: begin
            if (press_mode) begin
               state_d = SET_MIN;
            end else if (press_inc) begin
               hour_d  = (hour == 5'd23) ? '0 : hour + 5'd1;
               phase_d = 1'b0;
            end
         end
         SET_MIN: begin
            // Leaving set mode restarts the second so the next tick is a full second away.
            if (press_mode) begin
               state_d  = RUN;
               second_d = '0;
               cnt_d    = '0;
            end else if (press_inc) begin
               minute_d = (minute == 6'd59) ? '0 : minute + 6'd1;
               phase_d  = 1'b0;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Button history resets high so a button held through reset is not a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         hour       <= '0;
         minute     <= '0;
         second     <= '0;
         btn_mode_q <= 1'b1;
         btn_inc_q  <= 1'b1;
         blink_hour <= 1'b0;
         blink_min  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         hour       <= hour_d;
         minute     <= minute_d;
         second     <= second_d;
         btn_mode_q <= btn_mode;
         btn_inc_q  <= btn_inc;
         blink_hour <= (state_d == SET_HOUR) & phase_d;
         blink_min  <= (state_d == SET_MIN) & phase_d;
      end
   end

endmodule

// File: tb/tb_clock_time_controller.sv
// Scoreboard bench for clock_time_controller with TICKS_PER_SEC = 4: stimulus queues
// hand-computed snapshots, a monitor compares them against the outputs at the falling edge.
module tb_clock_time_controller;

   logic       clk = 1'b0;
   logic       reset, btn_mode, btn_inc;
   logic       sec_tick;
   logic [4:0] hour;
   logic [5:0] minute, second;
   logic [1:0] mode;
   logic       blink_hour, blink_min;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic [1:0] md;
      logic       bh, bm, tk;
      logic       bh_x, bm_x, tk_x;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

   clock_time_controller #(.TICKS_PER_SEC(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .sec_tick  (sec_tick),
      .hour      (hour),
      .minute    (minute),
      .second    (second),
      .mode      (mode),
      .blink_hour(blink_hour),
      .blink_min (blink_min)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // -1 on bh/bm/tk marks that flag as don't-care
   task automatic chk(input string nm, input int h, input int m, input int s, input int md,
                      input int bh, input int bm, input int tk);
      exp_t e;
      e.h    = 5'(h);
      e.m    = 6'(m);
      e.s    = 6'(s);
      e.md   = 2'(md);
      e.bh_x = (bh < 0);
      e.bm_x = (bm < 0);
      e.tk_x = (tk < 0);
      e.bh   = (bh > 0);
      e.bm   = (bm > 0);
      e.tk   = (tk > 0);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic press_mode_btn();
      btn_mode = 1'b1;
      step();
      btn_mode = 1'b0;
      step();
   endtask

   task automatic press_inc_n(input int n);
      for (int i = 0; i < n; i++) begin
         btn_inc = 1'b1;
         step();
         btn_inc = 1'b0;
         step();
      end
   endtask

   // Monitor: drains every queued expectation against the settled outputs
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         logic  bad;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_vec++;
         bad = (hour !== e.h) || (minute !== e.m) || (second !== e.s) || (mode !== e.md) ||
               (!e.bh_x && blink_hour !== e.bh) || (!e.bm_x && blink_min !== e.bm) ||
               (!e.tk_x && sec_tick !== e.tk);
         if (bad) begin
            n_bad++;
            $display("FAIL %s: got %0d:%0d:%0d mode=%0d bh=%b bm=%b tick=%b, want %0d:%0d:%0d mode=%0d bh=%s bm=%s tick=%s",
                     nm, hour, minute, second, mode, blink_hour, blink_min, sec_tick,
                     e.h, e.m, e.s, e.md,
                     e.bh_x ? "x" : (e.bh ? "1" : "0"),
                     e.bm_x ? "x" : (e.bm ? "1" : "0"),
                     e.tk_x ? "x" : (e.tk ? "1" : "0"));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("reset", 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         step();
         chk("count", 0, 0, k / 4, 0, 0, 0, (k % 4 == 3) ? 1 : 0);
      end

      // Set 23:59 with both wraps exercised
      press_mode_btn();
      chk("enter_set_hour", 0, 0, 3, 1, -1, 0, -1);
      press_inc_n(23);
      chk("hour_23", 23, 0, 3, 1, -1, 0, -1);
      btn_inc = 1'b1;
      step();
      chk("hour_wrap", 0, 0, 3, 1, 0, 0, -1);
      btn_inc = 1'b0;
      step();
      press_inc_n(23);
      press_mode_btn();
      chk("enter_set_min", 23, 0, 3, 2, 0, -1, -1);
      press_inc_n(59);
      chk("min_59", 23, 59, 3, 2, 0, -1, -1);
      btn_inc = 1'b1;
      step();
      chk("min_wrap", 23, 0, 3, 2, 0, 0, -1);
      btn_inc = 1'b0;
      step();
      press_inc_n(59);
      btn_inc = 1'b1;
      repeat (10) step();
      btn_inc = 1'b0;
      step();
      chk("hold_inc", 23, 0, 3, 2, 0, -1, -1);
      press_inc_n(59);
      repeat (80) step();
      chk("frozen", 23, 59, 3, 2, 0, -1, -1);

      // Exit clears seconds and restarts the prescaler
      btn_mode = 1'b1;
      step();
      chk("exit", 23, 59, 0, 0, 0, 0, 0);
      btn_mode = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("exit_tick", 23, 59, (k == 4) ? 1 : 0, 0, 0, 0, (k == 3) ? 1 : 0);
      end
      repeat (232) step();
      chk("at_235959", 23, 59, 59, 0, 0, 0, 0);
      repeat (3) step();
      chk("pre_roll", 23, 59, 59, 0, 0, 0, 1);
      step();
      chk("rollover", 0, 0, 0, 0, 0, 0, 0);

      // Mode press on the same edge as a carrying tick
      repeat (236) step();
      chk("at_0059", 0, 0, 59, 0, 0, 0, 0);
      repeat (3) step();
      btn_mode = 1'b1;
      step();
      chk("mode_on_tick", 0, 1, 0, 1, -1, 0, 0);
      btn_mode = 1'b0;
      step();

      press_inc_n(5);
      chk("hour_5", 5, 1, 0, 1, -1, 0, -1);
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      step();
      chk("simul_press", 5, 1, 0, 2, 0, -1, -1);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step();

      reset = 1'b1;
      step();
      chk("reset_mid_set", 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;

      // Blink phase from a known reset alignment
      step();
      btn_mode = 1'b1;
      step();
      chk("blink_on", 0, 0, 0, 1, 1, 0, 0);
      btn_mode = 1'b0;
      step();
      step();
      chk("blink_off", 0, 0, 0, 1, 0, 0, 0);

      btn_mode = 1'b1;
      reset    = 1'b1;
      step();
      step();
      reset = 1'b0;
      repeat (5) step();
      chk("held_thru_reset", 0, 0, 1, 0, 0, 0, 0);
      btn_mode = 1'b0;
      btn_inc  = 1'b1;
      step();
      btn_inc = 1'b0;
      chk("inc_ignored_run", 0, 0, 1, 0, 0, 0, 0);

      step();
      step();
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
